// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a train of `count` strobes on sig, one every `period`
// cycles, each HIGH_CYCLES wide, with a start/busy/done handshake.
// Optional feature macro: PULSE_TRAIN_ABORT_EN adds an `abort` input that
// cancels a running train without pulsing done.
module pulse_train_gen #(
  parameter  int MAX_PERIOD  = 255,
  parameter  int MAX_PULSES  = 255,
  parameter  int HIGH_CYCLES = 1,
  localparam int PW          = $clog2(MAX_PERIOD + 1),
  localparam int NW          = $clog2(MAX_PULSES + 1)
) (
  input  logic          CLKB,
  input  logic          rst,
  input  logic          start,
`ifdef PULSE_TRAIN_ABORT_EN
  input  logic          abort,
`endif
  input  logic [PW-1:0] period,
  input  logic [NW-1:0] count,
  output logic          sig,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Shortest legal period: every pulse needs at least one low cycle.
  localparam logic [PW-1:0] MIN_PER = PW'(HIGH_CYCLES + 1);
  // Phase counter counts down to zero, so loads are (length - 1).
  localparam logic [PW-1:0] HI_LOAD = PW'(HIGH_CYCLES - 1);
  localparam logic [PW-1:0] HI_W    = PW'(HIGH_CYCLES);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] per_q, per_d;
  logic [NW-1:0] rem_q, rem_d;
  logic          sig_q, sig_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          abort_w;
  logic [PW-1:0] per_clamped;
  logic [PW-1:0] low_load;

`ifdef PULSE_TRAIN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Too-short periods (including 0) are silently widened to the minimum.
  assign per_clamped = (period < MIN_PER) ? MIN_PER : period;
  // Low phase fills the rest of the period; never negative after the clamp.
  assign low_load    = per_q - HI_W - PW'(1);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    per_d   = per_q;
    rem_d   = rem_q;
    sig_d   = sig_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        sig_d  = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          if (count != '0) begin
            per_d   = per_clamped;
            rem_d   = count - NW'(1);
            phase_d = HI_LOAD;
            state_d = HIGH;
            sig_d   = 1'b1;
            busy_d  = 1'b1;
          end else begin
            // Empty train: acknowledge immediately, never go busy.
            done_d = 1'b1;
          end
        end
      end

      HIGH: begin
        if (phase_q == '0) begin
          state_d = LOW;
          sig_d   = 1'b0;
          phase_d = low_load;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end

      LOW: begin
        if (phase_q == '0) begin
          if (rem_q != '0) begin
            state_d = HIGH;
            sig_d   = 1'b1;
            rem_d   = rem_q - NW'(1);
            phase_d = HI_LOAD;
          end else begin
            // Train complete: drop busy and pulse done in the same cycle,
            // which is also an IDLE cycle so a new start is accepted.
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        sig_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Abort cancels a running train quietly; it is meaningless in IDLE,
    // so start wins automatically when both arrive there.
    if (abort_w && (state_q != IDLE)) begin
      state_d = IDLE;
      phase_d = '0;
      rem_d   = '0;
      sig_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge CLKB) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      per_q   <= '0;
      rem_q   <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sig       = sig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule
